// File: rtl/nec_motor_ctrl_mc.sv
// rtl/nec_motor_ctrl_mc.sv - multi-channel motor controller driven by decoded NEC IR frames
//
// Purpose:
//   Checks each decoded NEC frame, then executes exactly one command per strobe:
//   ON/OFF on the selected channel, duty target UP/DOWN, channel select, all-off.
//   REPEAT strobes re-issue the last UP/DOWN. Every channel's duty output ramps
//   toward its goal one LSB per prescaler period. The goal is the target while
//   the channel is on and zero while it is off.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active high
//   frame_vld_i  one-cycle strobe, frame_i holds a new frame
//   frame_i      [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd
//   repeat_i     one-cycle strobe, NEC repeat code received
//   sw_o         per-channel enable
//   rate_set_o   ramped duty, channel i at [i*DUTY_W +: DUTY_W]
//   ch_sel_o     channel addressed by ON/OFF/UP/DOWN
//   cmd_ack_o    one-cycle pulse, command executed
//   cmd_err_o    one-cycle pulse, frame rejected

module nec_motor_ctrl_mc #(
    parameter int         NCH      = 2,
    parameter int         DUTY_W   = 7,
    parameter int         STEP     = 10,
    parameter int         DUTY_MAX = 90,
    parameter int         WRAP     = 0,
    parameter int         RAMP_DIV = 1000,
    parameter logic [7:0] ADDR     = 8'h00,
    parameter bit         ADDR_CHK = 1'b1,
    parameter bit         REP_EN   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    frame_vld_i,
    input  logic [31:0]             frame_i,
    input  logic                    repeat_i,
    output logic [NCH-1:0]          sw_o,
    output logic [NCH*DUTY_W-1:0]   rate_set_o,
    output logic [2:0]              ch_sel_o,
    output logic                    cmd_ack_o,
    output logic                    cmd_err_o
);

    localparam logic [7:0] CMD_ON      = 8'h45;
    localparam logic [7:0] CMD_OFF     = 8'h44;
    localparam logic [7:0] CMD_UP      = 8'h09;
    localparam logic [7:0] CMD_DOWN    = 8'h15;
    localparam logic [7:0] CMD_CH_NEXT = 8'h40;
    localparam logic [7:0] CMD_ALL_OFF = 8'h47;

    // UP is summed one bit wider so a carry past DUTY_MAX is never lost.
    localparam logic [DUTY_W:0]   STEP_X = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W:0]   MAX_X  = (DUTY_W+1)'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] STEP_T = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] MAX_T  = DUTY_W'(DUTY_MAX);

    localparam int              PS_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'((RAMP_DIV > 0) ? RAMP_DIV - 1 : 0);

    typedef enum logic [1:0] {
        LAST_NONE,
        LAST_UP,
        LAST_DOWN,
        LAST_OTHER
    } last_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ON,
        OP_OFF,
        OP_UP,
        OP_DOWN,
        OP_CH_NEXT,
        OP_ALL_OFF
    } op_t;

    logic [NCH-1:0]    sw_q, sw_d;
    logic [2:0]        ch_sel_q, ch_sel_d;
    logic [DUTY_W-1:0] tgt_q  [NCH];
    logic [DUTY_W-1:0] tgt_d  [NCH];
    logic [DUTY_W-1:0] rate_q [NCH];
    logic [DUTY_W-1:0] rate_d [NCH];
    logic [DUTY_W-1:0] goal   [NCH];
    last_t             last_q, last_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [PS_W-1:0]   ps_q, ps_d;

    logic [7:0]        cmd;
    logic              frame_ok;
    op_t               op;
    logic [DUTY_W-1:0] cur_tgt;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W-1:0] up_val;
    logic [DUTY_W-1:0] dn_val;
    logic              tick;

    assign cmd      = frame_i[23:16];
    assign frame_ok = (frame_i[31:24] == ~cmd) &&
                      (!ADDR_CHK || ((frame_i[7:0] == ADDR) && (frame_i[15:8] == ~ADDR)));

    // A valid frame always wins over a simultaneous REPEAT strobe.
    always_comb begin
        op = OP_NONE;
        if (frame_vld_i) begin
            if (frame_ok) begin
                case (cmd)
                    CMD_ON:      op = OP_ON;
                    CMD_OFF:     op = OP_OFF;
                    CMD_UP:      op = OP_UP;
                    CMD_DOWN:    op = OP_DOWN;
                    CMD_CH_NEXT: op = OP_CH_NEXT;
                    CMD_ALL_OFF: op = OP_ALL_OFF;
                    default:     op = OP_NONE;
                endcase
            end
        end else if (repeat_i && REP_EN) begin
            if (last_q == LAST_UP) begin
                op = OP_UP;
            end else if (last_q == LAST_DOWN) begin
                op = OP_DOWN;
            end
        end
    end

    // Target of the selected channel, plus its UP/DOWN results.
    always_comb begin
        cur_tgt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel_q == 3'(i)) begin
                cur_tgt = tgt_q[i];
            end
        end
        up_sum = {1'b0, cur_tgt} + STEP_X;
        if (up_sum > MAX_X) begin
            up_val = (WRAP != 0) ? '0 : MAX_T;
        end else begin
            up_val = up_sum[DUTY_W-1:0];
        end
        if (cur_tgt < STEP_T) begin
            dn_val = (WRAP != 0) ? MAX_T : '0;
        end else begin
            dn_val = cur_tgt - STEP_T;
        end
    end

    always_comb begin
        sw_d     = sw_q;
        ch_sel_d = ch_sel_q;
        last_d   = last_q;
        ack_d    = 1'b0;
        err_d    = frame_vld_i && !frame_ok;
        for (int i = 0; i < NCH; i++) begin
            tgt_d[i] = tgt_q[i];
        end

        if (op != OP_NONE) begin
            ack_d = 1'b1;
        end

        case (op)
            OP_ON: begin
                for (int i = 0; i < NCH; i++) begin
                    if (ch_sel_q == 3'(i)) sw_d[i] = 1'b1;
                end
                last_d = LAST_OTHER;
            end
            OP_OFF: begin
                for (int i = 0; i < NCH; i++) begin
                    if (ch_sel_q == 3'(i)) sw_d[i] = 1'b0;
                end
                last_d = LAST_OTHER;
            end
            OP_UP: begin
                for (int i = 0; i < NCH; i++) begin
                    if (ch_sel_q == 3'(i)) tgt_d[i] = up_val;
                end
                last_d = LAST_UP;
            end
            OP_DOWN: begin
                for (int i = 0; i < NCH; i++) begin
                    if (ch_sel_q == 3'(i)) tgt_d[i] = dn_val;
                end
                last_d = LAST_DOWN;
            end
            OP_CH_NEXT: begin
                ch_sel_d = (ch_sel_q == 3'(NCH - 1)) ? 3'd0 : ch_sel_q + 3'd1;
                // Recording CH_NEXT keeps a later REPEAT from hitting the new channel.
                last_d   = LAST_OTHER;
            end
            OP_ALL_OFF: begin
                sw_d   = '0;
                last_d = LAST_OTHER;
            end
            default: begin
            end
        endcase
    end

    // Free-running prescaler; its terminal count paces the ramp.
    assign tick = (RAMP_DIV != 0) && (ps_q == PS_LAST);

    always_comb begin
        if (RAMP_DIV == 0 || tick) begin
            ps_d = '0;
        end else begin
            ps_d = ps_q + 1'b1;
        end
    end

    // Ramping always starts from the current output, so a retarget never jumps.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            goal[i]   = sw_q[i] ? tgt_q[i] : '0;
            rate_d[i] = rate_q[i];
            if (RAMP_DIV == 0) begin
                rate_d[i] = goal[i];
            end else if (tick) begin
                if (rate_q[i] < goal[i]) begin
                    rate_d[i] = rate_q[i] + 1'b1;
                end else if (rate_q[i] > goal[i]) begin
                    rate_d[i] = rate_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_q     <= '0;
            ch_sel_q <= '0;
            last_q   <= LAST_NONE;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            ps_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                tgt_q[i]  <= '0;
                rate_q[i] <= '0;
            end
        end else begin
            sw_q     <= sw_d;
            ch_sel_q <= ch_sel_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            ps_q     <= ps_d;
            for (int i = 0; i < NCH; i++) begin
                tgt_q[i]  <= tgt_d[i];
                rate_q[i] <= rate_d[i];
            end
        end
    end

    always_comb begin
        rate_set_o = '0;
        for (int i = 0; i < NCH; i++) begin
            rate_set_o[i*DUTY_W +: DUTY_W] = rate_q[i];
        end
    end

    assign sw_o      = sw_q;
    assign ch_sel_o  = ch_sel_q;
    assign cmd_ack_o = ack_q;
    assign cmd_err_o = err_q;

endmodule

// File: tb/tb_nec_motor_ctrl_mc.sv
// tb/tb_nec_motor_ctrl_mc.sv - self-checking bench for nec_motor_ctrl_mc

module tb_nec_motor_ctrl_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_vld;
    logic        repeat_s;
    logic [31:0] frame;

    always #5 clk = ~clk;

    logic [1:0]  sw0, sw1, sw2;
    logic [13:0] rs0, rs1, rs2;
    logic [2:0]  ch0, ch1, ch2;
    logic        ack0, ack1, ack2, err0, err1, err2;

    // u0: immediate follow, saturating; u1: immediate follow, wrapping; u2: ramp of 4 clk/LSB
    nec_motor_ctrl_mc #(.NCH(2), .WRAP(0), .RAMP_DIV(0)) u0 (
        .clk_i(clk), .rst_i(rst), .frame_vld_i(frame_vld), .frame_i(frame), .repeat_i(repeat_s),
        .sw_o(sw0), .rate_set_o(rs0), .ch_sel_o(ch0), .cmd_ack_o(ack0), .cmd_err_o(err0));
    nec_motor_ctrl_mc #(.NCH(2), .WRAP(1), .RAMP_DIV(0)) u1 (
        .clk_i(clk), .rst_i(rst), .frame_vld_i(frame_vld), .frame_i(frame), .repeat_i(repeat_s),
        .sw_o(sw1), .rate_set_o(rs1), .ch_sel_o(ch1), .cmd_ack_o(ack1), .cmd_err_o(err1));
    nec_motor_ctrl_mc #(.NCH(2), .WRAP(0), .RAMP_DIV(4)) u2 (
        .clk_i(clk), .rst_i(rst), .frame_vld_i(frame_vld), .frame_i(frame), .repeat_i(repeat_s),
        .sw_o(sw2), .rate_set_o(rs2), .ch_sel_o(ch2), .cmd_ack_o(ack2), .cmd_err_o(err2));

    typedef struct packed {
        logic       ack;
        logic       err;
        logic [1:0] sw;
        logic [2:0] ch;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    logic [1:0] m_sw;
    logic [2:0] m_ch;
    int         t0 [2];
    int         t1 [2];
    int         m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int up_f(input int t, input bit w);
        return (t + 10 > 90) ? (w ? 0 : 90) : t + 10;
    endfunction

    function automatic int dn_f(input int t, input bit w);
        return (t < 10) ? (w ? 90 : 0) : t - 10;
    endfunction

    function automatic logic [31:0] fr(input logic [7:0] c);
        return {~c, c, 8'hFF, 8'h00};
    endfunction

    task automatic model_reset();
        m_sw = 2'b00; m_ch = 3'd0; m_last = 0;
        t0[0] = 0; t0[1] = 0; t1[0] = 0; t1[1] = 0;
    endtask

    task automatic push_exp(input logic a, input logic e);
        exp_t x;
        x.ack = a; x.err = e; x.sw = m_sw; x.ch = m_ch;
        q.push_back(x);
    endtask

    task automatic model_frame(input logic [31:0] f);
        logic [7:0] c;
        c = f[23:16];
        if (!((f[31:24] == ~c) && (f[7:0] == 8'h00) && (f[15:8] == 8'hFF))) begin
            push_exp(1'b0, 1'b1);
            return;
        end
        case (c)
            8'h45: m_sw[m_ch[0]] = 1'b1;
            8'h44: m_sw[m_ch[0]] = 1'b0;
            8'h09: begin t0[m_ch[0]] = up_f(t0[m_ch[0]], 0); t1[m_ch[0]] = up_f(t1[m_ch[0]], 1); end
            8'h15: begin t0[m_ch[0]] = dn_f(t0[m_ch[0]], 0); t1[m_ch[0]] = dn_f(t1[m_ch[0]], 1); end
            8'h40: m_ch = (m_ch == 3'd1) ? 3'd0 : 3'd1;
            8'h47: m_sw = 2'b00;
            default: return;
        endcase
        m_last = (c == 8'h09) ? 1 : (c == 8'h15) ? 2 : 3;
        push_exp(1'b1, 1'b0);
    endtask

    task automatic model_rep();
        if (m_last == 1) begin
            t0[m_ch[0]] = up_f(t0[m_ch[0]], 0); t1[m_ch[0]] = up_f(t1[m_ch[0]], 1);
        end else if (m_last == 2) begin
            t0[m_ch[0]] = dn_f(t0[m_ch[0]], 0); t1[m_ch[0]] = dn_f(t1[m_ch[0]], 1);
        end else begin
            return;
        end
        push_exp(1'b1, 1'b0);
    endtask

    task automatic send(input logic [31:0] f, input logic rep);
        @(posedge clk); #1;
        frame = f; frame_vld = 1'b1; repeat_s = rep;
        model_frame(f);
        @(posedge clk); #1;
        frame = '0; frame_vld = 1'b0; repeat_s = 1'b0;
    endtask

    task automatic send_rep();
        @(posedge clk); #1;
        repeat_s = 1'b1;
        model_rep();
        @(posedge clk); #1;
        repeat_s = 1'b0;
    endtask

    // RAMP_DIV=0 outputs trail the target by one clock.
    task automatic check_rates(input string tag);
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            chk({tag, " u0 rate"}, 32'(rs0[c*7 +: 7]), m_sw[c] ? t0[c] : 0);
            chk({tag, " u1 rate"}, 32'(rs1[c*7 +: 7]), m_sw[c] ? t1[c] : 0);
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk({tag, " sw0"}, 32'(sw0), 0);
        chk({tag, " rs0"}, 32'(rs0), 0);
        chk({tag, " ch0"}, 32'(ch0), 0);
        chk({tag, " rs2"}, 32'(rs2), 0);
        chk({tag, " sw2"}, 32'(sw2), 0);
        chk({tag, " ack/err"}, {ack0, err0, ack2, err2}, 0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; frame_vld = 1'b0; repeat_s = 1'b0; frame = '0;
        model_reset();

        fork
            forever begin
                @(negedge clk);
                if (!rst && (ack0 || err0 || ack1 || err1 || ack2 || err2)) begin
                    if (q.size() == 0) begin
                        chk("unexpected ack/err", {ack0, err0, ack1, err1, ack2, err2}, 0);
                    end else begin
                        e = q.pop_front();
                        chk("ack0", 32'(ack0), 32'(e.ack));
                        chk("err0", 32'(err0), 32'(e.err));
                        chk("sw0", 32'(sw0), 32'(e.sw));
                        chk("ch0", 32'(ch0), 32'(e.ch));
                        chk("ack1", 32'(ack1), 32'(e.ack));
                        chk("sw1", 32'(sw1), 32'(e.sw));
                        chk("ack2", 32'(ack2), 32'(e.ack));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset sw", 32'(sw0), 0);
        chk("reset rate", 32'(rs0), 0);
        chk("reset ch_sel", 32'(ch0), 0);
        chk("reset ack/err", {ack0, err0}, 0);
        chk("reset rate u2", 32'(rs2), 0);

        // ON with target 0: channel enabled, duty stays 0
        send(fr(8'h45), 1'b0);
        check_rates("on");

        // 11x UP: 10..90 then saturate (u1 wraps to 0, then 10)
        for (int k = 0; k < 11; k++) begin
            send(fr(8'h09), 1'b0);
            check_rates("up");
        end
        chk("u0 saturated", 32'(rs0[6:0]), 90);
        chk("u1 wrapped", 32'(rs1[6:0]), 10);

        // DOWN twice: u1 goes 10 -> 0 -> 90 (wrap)
        send(fr(8'h15), 1'b0); check_rates("down");
        send(fr(8'h15), 1'b0); check_rates("down");
        chk("u1 down wrap", 32'(rs1[6:0]), 90);

        // rejected frames and unknown command
        send({8'h00, 8'h45, 8'hFF, 8'h00}, 1'b0); check_rates("bad ncmd");
        send({~8'h45, 8'h45, 8'hFE, 8'h01}, 1'b0); check_rates("bad addr");
        send(fr(8'h12), 1'b0); check_rates("unknown");

        // repeat behaviour from a clean state
        do_reset("reset mid-op");
        send(fr(8'h45), 1'b0);
        send(fr(8'h09), 1'b0);
        for (int k = 0; k < 3; k++) send_rep();
        check_rates("repeat");
        chk("repeat target", 32'(rs0[6:0]), 40);
        send(fr(8'h40), 1'b0);
        send_rep();
        check_rates("repeat after ch_next");
        send(fr(8'h09), 1'b0);
        send(fr(8'h45), 1'b1);
        check_rates("frame+repeat");
        chk("ch1 only", 32'(rs0[13:7]), 10);

        // channel select, all-off keeps targets
        send(fr(8'h09), 1'b0); check_rates("ch1 up");
        chk("ch0 untouched", 32'(rs0[6:0]), 40);
        send(fr(8'h40), 1'b0);
        chk("ch_sel wrap", 32'(ch0), 0);
        send(fr(8'h47), 1'b0); check_rates("all off");
        chk("all off sw", 32'(sw0), 0);
        send(fr(8'h45), 1'b0); check_rates("targets kept");

        // ramp at 4 clocks per LSB
        do_reset("reset pre-ramp");
        send(fr(8'h45), 1'b0);
        send(fr(8'h09), 1'b0);
        repeat (20) @(posedge clk);
        #1 chk("ramp up half", 32'(rs2[6:0]), 5);
        repeat (20) @(posedge clk);
        #1 chk("ramp up full", 32'(rs2[6:0]), 10);
        repeat (20) @(posedge clk);
        #1 chk("ramp hold", 32'(rs2[6:0]), 10);
        send(fr(8'h44), 1'b0);
        repeat (20) @(posedge clk);
        #1 chk("ramp down half", 32'(rs2[6:0]), 5);
        repeat (20) @(posedge clk);
        #1 chk("ramp down full", 32'(rs2[6:0]), 0);

        // reset in the middle of a ramp
        send(fr(8'h45), 1'b0);
        send(fr(8'h09), 1'b0);
        repeat (10) @(posedge clk);
        #1 chk("mid-ramp nonzero", 32'(rs2[6:0] != 7'd0), 1);
        do_reset("reset mid-ramp");

        repeat (3) @(posedge clk);
        #1 chk("scoreboard drained", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
